// File: rtl/bus_cycle_sequencer.sv
// Bus cycle sequencer: turns core transfer requests into 4-phase bus cycles aligned to the q phase count.
// Latency: request accepted at the q=3 edge, ack pulse 4 fclk later (plus 4 fclk per wait cycle).
// Backpressure: req is a level held until ack; rdy_in=0 at q=3 stretches the cycle (BUS_WAIT_STATE_EN only).
//
// Optional feature: define BUS_WAIT_STATE_EN to honour rdy_in (WAIT state); undefined, rdy_in is ignored.
//
// Ports:
//   fclk, resb           fast clock, async active-low reset
//   q, p                 phase count (0..3) and phi2-equivalent from the timing generator
//   req/we/fetch/addr/wdata  core request; ack/rdata/busy back to the core
//   a_out/rwb/d_out/d_oe/sync  registered bus outputs; d_in/rdy_in from the bus
module bus_cycle_sequencer (
    input  logic        fclk,
    input  logic        resb,
    input  logic [1:0]  q,
    input  logic        p,
    input  logic        req,
    input  logic        we,
    input  logic        fetch,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [15:0] a_out,
    output logic        rwb,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in,
    output logic        sync,
    input  logic        rdy_in
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} state_t;

    state_t      state, state_nxt;
    logic [15:0] addr_l, addr_l_nxt;
    logic [7:0]  wdata_l, wdata_l_nxt;
    logic        we_l, we_l_nxt;
    logic        fetch_l, fetch_l_nxt;

    logic [15:0] a_out_nxt;
    logic        rwb_nxt;
    logic [7:0]  d_out_nxt;
    logic        d_oe_nxt;
    logic        sync_nxt;
    logic        ack_nxt;
    logic [7:0]  rdata_nxt;

    logic        last_phase;
    logic        next_p;
    logic        accept;
    logic        bus_ready;

`ifdef BUS_WAIT_STATE_EN
    assign bus_ready = rdy_in;
`else
    assign bus_ready = 1'b1;
    logic unused_rdy_in;
    assign unused_rdy_in = rdy_in;
`endif

    // q wrap 3->0 is the only cycle boundary: acceptance and completion both happen here.
    assign last_phase = (q == 2'd3);

    // p in the cycle after this edge: p rises after q=1 and falls after q=3, i.e. it toggles
    // exactly when q is odd. Needed because d_oe is registered but must track p.
    assign next_p = p ^ q[0];

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        addr_l_nxt  = addr_l;
        wdata_l_nxt = wdata_l;
        we_l_nxt    = we_l;
        fetch_l_nxt = fetch_l;
        a_out_nxt   = a_out;
        rwb_nxt     = rwb;
        d_out_nxt   = d_out;
        sync_nxt    = sync;
        rdata_nxt   = rdata;
        ack_nxt     = 1'b0;
        accept      = 1'b0;

        case (state)
            IDLE: begin
                if (req && last_phase) begin
                    accept = 1'b1;
                end
            end
            ADDR: begin
                if (q == 2'd1) begin
                    state_nxt = DATA;
                    d_out_nxt = wdata_l;
                end
            end
            DATA, WAIT: begin
                if (last_phase) begin
                    if (bus_ready) begin
                        ack_nxt = 1'b1;
                        if (!we_l) begin
                            rdata_nxt = d_in;
                        end
                        if (req) begin
                            accept = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            rwb_nxt   = 1'b1;
                            sync_nxt  = 1'b0;
                        end
                    end else begin
                        // Bus not ready: repeat a full 4-phase cycle with everything held.
                        state_nxt = WAIT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Shared by first acceptance and back-to-back acceptance at completion.
        if (accept) begin
            state_nxt   = ADDR;
            addr_l_nxt  = addr;
            wdata_l_nxt = wdata;
            we_l_nxt    = we;
            fetch_l_nxt = fetch;
            a_out_nxt   = addr;
            rwb_nxt     = ~we;
            sync_nxt    = fetch;
        end

        // Drive only during the p-high half of a data cycle of a write.
        d_oe_nxt = we_l_nxt & next_p & ((state_nxt == DATA) || (state_nxt == WAIT));
    end

    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            state   <= IDLE;
            addr_l  <= 16'h0000;
            wdata_l <= 8'h00;
            we_l    <= 1'b0;
            fetch_l <= 1'b0;
            a_out   <= 16'h0000;
            rwb     <= 1'b1;
            d_out   <= 8'h00;
            d_oe    <= 1'b0;
            sync    <= 1'b0;
            ack     <= 1'b0;
            rdata   <= 8'h00;
        end else begin
            state   <= state_nxt;
            addr_l  <= addr_l_nxt;
            wdata_l <= wdata_l_nxt;
            we_l    <= we_l_nxt;
            fetch_l <= fetch_l_nxt;
            a_out   <= a_out_nxt;
            rwb     <= rwb_nxt;
            d_out   <= d_out_nxt;
            d_oe    <= d_oe_nxt;
            sync    <= sync_nxt;
            ack     <= ack_nxt;
            rdata   <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
module tb_bus_cycle_sequencer;

    logic        fclk = 1'b0;
    logic        resb;
    logic [1:0]  q;
    logic        p;
    logic        req;
    logic        we;
    logic        fetch;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [15:0] a_out;
    logic        rwb;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  d_in;
    logic        sync;
    logic        rdy_in;

    int errors = 0;
    int checks = 0;

    bus_cycle_sequencer dut (
        .fclk   (fclk),
        .resb   (resb),
        .q      (q),
        .p      (p),
        .req    (req),
        .we     (we),
        .fetch  (fetch),
        .addr   (addr),
        .wdata  (wdata),
        .ack    (ack),
        .rdata  (rdata),
        .busy   (busy),
        .a_out  (a_out),
        .rwb    (rwb),
        .d_out  (d_out),
        .d_oe   (d_oe),
        .d_in   (d_in),
        .sync   (sync),
        .rdy_in (rdy_in)
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One fclk: inputs (including the phase generator) change 1 time unit after the edge.
    task automatic tick();
        @(posedge fclk);
        #1;
        q = q + 2'd1;
        p = q[1];
    endtask

    task automatic align3();
        for (int i = 0; i < 4; i++) begin
            if (q != 2'd3) tick();
        end
    endtask

    typedef struct {
        logic        we;
        logic        fetch;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic        exp_rwb;
        logic        exp_sync;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int ack_t[3];
        int acks;
        int ack_at;
        logic busy_gap;
        logic ack_seen;
        logic [15:0] a_hold;
        logic busy_hold;

        vecs[0] = '{we: 1'b0, fetch: 1'b0, addr: 16'h1234, wdata: 8'h00, din: 8'hA5, exp_rwb: 1'b1, exp_sync: 1'b0, exp_rdata: 8'hA5};
        vecs[1] = '{we: 1'b1, fetch: 1'b0, addr: 16'hFFFC, wdata: 8'h3C, din: 8'h66, exp_rwb: 1'b0, exp_sync: 1'b0, exp_rdata: 8'hA5};
        vecs[2] = '{we: 1'b0, fetch: 1'b1, addr: 16'h8000, wdata: 8'h12, din: 8'h5A, exp_rwb: 1'b1, exp_sync: 1'b1, exp_rdata: 8'h5A};
        vecs[3] = '{we: 1'b1, fetch: 1'b0, addr: 16'h0000, wdata: 8'hFF, din: 8'h99, exp_rwb: 1'b0, exp_sync: 1'b0, exp_rdata: 8'h5A};
        vecs[4] = '{we: 1'b0, fetch: 1'b0, addr: 16'h0001, wdata: 8'h81, din: 8'h00, exp_rwb: 1'b1, exp_sync: 1'b0, exp_rdata: 8'h00};

        resb = 1'b0; q = 2'd0; p = 1'b0; req = 1'b0; we = 1'b0; fetch = 1'b0;
        addr = 16'h0000; wdata = 8'h00; d_in = 8'h00; rdy_in = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_a_out", 32'(a_out), 32'h0);
        chk("rst_rwb",   32'(rwb),   32'd1);
        chk("rst_d_out", 32'(d_out), 32'h0);
        chk("rst_d_oe",  32'(d_oe),  32'd0);
        chk("rst_sync",  32'(sync),  32'd0);
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_busy",  32'(busy),  32'd0);
        resb = 1'b1;

        // req at q=0,1,2 must not be accepted
        for (int i = 0; i < 4; i++) begin
            if (q != 2'd0) tick();
        end
        req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_accept_busy", 32'(busy), 32'd0);
        end
        req = 1'b0;
        tick();
        chk("no_req_busy", 32'(busy), 32'd0);

        // Single transfers from the table
        foreach (vecs[k]) begin
            align3();
            we = vecs[k].we; fetch = vecs[k].fetch; addr = vecs[k].addr; wdata = vecs[k].wdata;
            req = 1'b1; d_in = 8'h00;
            tick();  // ADDR, q=0
            req = 1'b0; addr = ~vecs[k].addr; wdata = ~vecs[k].wdata; we = ~vecs[k].we; fetch = ~vecs[k].fetch;
            chk("addr_a_out", 32'(a_out), 32'(vecs[k].addr));
            chk("addr_rwb",   32'(rwb),   32'(vecs[k].exp_rwb));
            chk("addr_sync",  32'(sync),  32'(vecs[k].exp_sync));
            chk("addr_busy",  32'(busy),  32'd1);
            chk("addr_d_oe",  32'(d_oe),  32'd0);
            chk("addr_ack",   32'(ack),   32'd0);
            tick();  // ADDR, q=1
            chk("addr1_d_oe",  32'(d_oe),  32'd0);
            chk("addr1_a_out", 32'(a_out), 32'(vecs[k].addr));
            tick();  // DATA, q=2
            chk("data2_d_oe",  32'(d_oe),  32'(vecs[k].we));
            chk("data2_d_out", 32'(d_out), 32'(vecs[k].wdata));
            chk("data2_rwb",   32'(rwb),   32'(vecs[k].exp_rwb));
            d_in = ~vecs[k].din;
            tick();  // DATA, q=3
            chk("data3_d_oe",  32'(d_oe),  32'(vecs[k].we));
            chk("data3_sync",  32'(sync),  32'(vecs[k].exp_sync));
            chk("data3_ack",   32'(ack),   32'd0);
            d_in = vecs[k].din;
            tick();  // completion cycle
            d_in = 8'h77; we = 1'b0; fetch = 1'b0;
            chk("done_ack",   32'(ack),   32'd1);
            chk("done_rdata", 32'(rdata), 32'(vecs[k].exp_rdata));
            chk("done_rwb",   32'(rwb),   32'd1);
            chk("done_sync",  32'(sync),  32'd0);
            chk("done_d_oe",  32'(d_oe),  32'd0);
            chk("done_busy",  32'(busy),  32'd0);
            chk("done_a_out", 32'(a_out), 32'(vecs[k].addr));
            tick();
            chk("ack_pulse", 32'(ack), 32'd0);
        end

        // Back-to-back: three reads with req held
        align3();
        we = 1'b0; fetch = 1'b0; addr = 16'h2000; d_in = 8'h11; req = 1'b1;
        tick();
        acks = 0; busy_gap = 1'b0;
        for (int t = 0; t <= 16; t++) begin
            if (t > 0) tick();
            addr = 16'h2000 + 16'((t + 1) / 4);
            if (ack) begin
                if (acks < 3) ack_t[acks] = t;
                acks++;
                if (acks == 2) req = 1'b0;
            end
            if (t < 12 && !busy) busy_gap = 1'b1;
        end
        chk("b2b_acks",  32'(acks),     32'd3);
        chk("b2b_ack0",  32'(ack_t[0]), 32'd4);
        chk("b2b_ack1",  32'(ack_t[1]), 32'd8);
        chk("b2b_ack2",  32'(ack_t[2]), 32'd12);
        chk("b2b_gap",   32'(busy_gap), 32'd0);
        chk("b2b_a_out", 32'(a_out),    32'h2002);
        chk("b2b_idle",  32'(busy),     32'd0);
        chk("b2b_rdata", 32'(rdata),    32'h11);

        // rdy_in low for two q=3 samples
        align3();
        we = 1'b0; addr = 16'h3000; d_in = 8'h5C; rdy_in = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        ack_at = -1; a_hold = 16'h0; busy_hold = 1'b0;
        for (int t = 0; t <= 16; t++) begin
            if (t > 0) tick();
            if (t == 8) rdy_in = 1'b1;
            if (ack && ack_at < 0) ack_at = t;
            if (t == 10) begin
                a_hold = a_out;
                busy_hold = busy;
            end
        end
`ifdef BUS_WAIT_STATE_EN
        chk("wait_ack_at", 32'(ack_at),    32'd12);
        chk("wait_busy",   32'(busy_hold), 32'd1);
`else
        chk("wait_ack_at", 32'(ack_at),    32'd4);
        chk("wait_busy",   32'(busy_hold), 32'd0);
`endif
        chk("wait_a_out", 32'(a_hold), 32'h3000);
        chk("wait_rdata", 32'(rdata),  32'h5C);
        rdy_in = 1'b1;

        // Reset during DATA of a write
        align3();
        we = 1'b1; addr = 16'h4000; wdata = 8'h99; req = 1'b1;
        tick();
        req = 1'b0;
        tick(); tick();  // DATA, q=2
        chk("prerst_d_oe", 32'(d_oe), 32'd1);
        #1 resb = 1'b0;
        #1;
        chk("midrst_d_oe",  32'(d_oe),  32'd0);
        chk("midrst_rwb",   32'(rwb),   32'd1);
        chk("midrst_busy",  32'(busy),  32'd0);
        chk("midrst_a_out", 32'(a_out), 32'h0);
        chk("midrst_d_out", 32'(d_out), 32'h0);
        tick(); tick();
        resb = 1'b1;
        ack_seen = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (ack) ack_seen = 1'b1;
        end
        chk("rst_no_ack", 32'(ack_seen), 32'd0);
        align3();
        we = 1'b0; addr = 16'h4444; d_in = 8'hC3; req = 1'b1;
        tick();
        req = 1'b0;
        tick(); tick(); tick(); tick();
        chk("postrst_ack",   32'(ack),   32'd1);
        chk("postrst_rdata", 32'(rdata), 32'hC3);
        chk("postrst_a_out", 32'(a_out), 32'h4444);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_cycle_sequencer.md
BUS_CYCLE_SEQUENCER -- requirements
Module: bus_cycle_sequencer

Interface
REQ-001 Clocking: one clock, fclk; reset resb is asynchronous and active-low.
REQ-002 fclk  in  1  system fast clock; same clock that drives the phase generator.
REQ-003 resb  in  1  async active-low reset.
REQ-004 q  in  2  phase count from timing control; 0,1,2,3 repeating, +1 per fclk.
REQ-005 p  in  1  phi2-equivalent from timing control; 1 during q=2,3, 0 during q=0,1.
REQ-006 req  in  1  core transfer request; level, held until ack.
REQ-007 we  in  1  1=write, 0=read; qualified by req.
REQ-008 fetch  in  1  opcode-fetch marker; qualified by req.
REQ-009 addr  in  16  transfer address.
REQ-010 wdata  in  8  write data.
REQ-011 ack  out  1  one-fclk completion pulse.
REQ-012 rdata  out  8  read data, valid from ack cycle until next read completes.
REQ-013 busy  out  1  1 while state != IDLE.
REQ-014 a_out  out  16  bus address.
REQ-015 rwb  out  1  bus read/write, 1=read.
REQ-016 d_out  out  8  bus write data.
REQ-017 d_oe  out  1  data bus drive enable.
REQ-018 d_in  in  8  bus read data.
REQ-019 sync  out  1  1 during a fetch transfer.
REQ-020 rdy_in  in  1  bus ready; 0 inserts wait cycles (see Configuration).

Function
REQ-021 States: IDLE, ADDR, DATA, WAIT; all outputs registered on fclk.
REQ-022 Acceptance: in IDLE, when req=1 and q=3, latch addr/wdata/we/fetch and enter ADDR; when q!=3, stay in IDLE with no latch.
REQ-023 ADDR (q=0,1): a_out=latched addr, rwb=~we, sync=fetch; move to DATA on the edge where q=1.
REQ-024 DATA (q=2,3): a_out/rwb/sync held; d_out=latched wdata; d_oe=we&p.
REQ-025 Completion at the edge where q=3 in DATA or WAIT and ready: ack=1 for the next fclk; on a read, rdata<=d_in.
REQ-026 Back-to-back: at completion, if req=1 (new transfer), latch it and go directly to ADDR; otherwise go to IDLE; steady throughput is 4 fclk per transfer.
REQ-027 Latency: req asserted with q=3 -> ack high 4 fclk later with zero waits.
REQ-028 IDLE outputs: a_out holds last address, rwb=1, d_oe=0, sync=0.
REQ-029 Changes to addr/wdata/we/fetch after acceptance have no effect on the current transfer.
REQ-030 q wrap 3->0 is the only cycle boundary; the block uses no other q transition for acceptance or completion.

Reset
REQ-031 resb=0 immediately forces IDLE, a_out=0, rwb=1, d_out=0, d_oe=0, sync=0, ack=0, rdata=0, busy=0, latches=0.
REQ-032 Reset mid-transfer aborts it with no ack; after release, the first acceptance occurs on the next q=3 with req=1.

Configuration
REQ-033 Macro BUS_WAIT_STATE_EN defined: at the q=3 edge in DATA/WAIT, rdy_in=0 enters/stays in WAIT (outputs held, d_oe=we&p) for another full 4-phase cycle; rdy_in=1 completes.
REQ-034 Macro undefined: rdy_in is ignored, WAIT is unreachable, and every transfer completes at the first q=3 edge in DATA.

Verification
REQ-035 Read: req=1, we=0, addr=16'h1234 presented at q=3, d_in=8'hA5 at q=3 of the next cycle -> a_out=16'h1234, rwb=1; ack pulse 4 fclk after acceptance; rdata=8'hA5.
REQ-036 Write: addr=16'hFFFC, wdata=8'h3C -> rwb=0, d_out=8'h3C, d_oe=1 only while p=1; ack after 4 fclk.
REQ-037 Back-to-back: req held for 3 transfers -> 3 acks spaced exactly 4 fclk, busy never 0 between transfers.
REQ-038 Wait (macro on): rdy_in=0 for 2 q=3 samples -> ack delayed by 8 fclk with bus held; macro off: same stimulus gives no delay.
REQ-039 Reset: resb low during DATA of a write -> d_oe=0, rwb=1, no ack; the next req at q=3 completes normally.
REQ-040 Sync: fetch=1 read -> sync=1 throughout ADDR/DATA, 0 in IDLE.
